// File: rtl/snitch_perf_sampler.sv
`default_nettype none
// ============================================================================
// Module   : snitch_perf_sampler
// Purpose  : Periodic snapshot unit for the cluster performance counters.
//            While armed (state RUN) it captures {timestamp, counters} every
//            max(interval_i,1) cycles into a small FIFO that drains through a
//            valid/ready stream towards a trace sink.
// Ports    : clk_i, rst_i (async, active-high)
//            cnt_i          - live counters, counter k at [k*CntWidth +: CntWidth]
//            start_i/stop_i - arm / disarm pulses (stop wins on collision)
//            interval_i     - sample period, latched on start and each reload
//            clear_i        - clears overflow_o and drop_cnt_o
//            sample_*       - snapshot stream {ts, cnt[NumCounters-1..0]}
//            busy_o, fill_o, overflow_o, drop_cnt_o - status
// Options  : define SNITCH_PERF_SAMPLER_DELTA_EN to emit per-counter deltas
//            against a baseline captured on start and after every accepted push.
// Revision : 1.0 - initial release
// ============================================================================
module snitch_perf_sampler #(
  parameter int unsigned NumCounters = 16,
  parameter int unsigned CntWidth    = 48,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned TsWidth     = 32
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NumCounters*CntWidth-1:0]         cnt_i,
  input  logic                                    start_i,
  input  logic                                    stop_i,
  input  logic [31:0]                             interval_i,
  input  logic                                    clear_i,
  output logic                                    sample_valid_o,
  input  logic                                    sample_ready_i,
  output logic [TsWidth+NumCounters*CntWidth-1:0] sample_data_o,
  output logic                                    busy_o,
  output logic [$clog2(FifoDepth):0]              fill_o,
  output logic                                    overflow_o,
  output logic [15:0]                             drop_cnt_o
);

  localparam int unsigned DATA_W = TsWidth + NumCounters*CntWidth;
  localparam int unsigned PTR_W  = $clog2(FifoDepth);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                          state;
  logic                            busy;
  logic [31:0]                     down_cnt;
  logic [TsWidth-1:0]              ts;
  logic [31:0]                     reload_val;
  logic                            sample_evt;

  logic [DATA_W-1:0]               mem [FifoDepth];
  logic [PTR_W-1:0]                wr_ptr;
  logic [PTR_W-1:0]                rd_ptr;
  logic [PTR_W:0]                  count;
  logic                            full;
  logic                            push;
  logic                            pop;
  logic                            drop;
  logic [NumCounters*CntWidth-1:0] cnt_field;

  // A zero interval behaves as one: sample every cycle.
  assign reload_val = (interval_i == 32'd0) ? 32'd1 : interval_i;

  // A start (restart) or stop in the same cycle suppresses the sample.
  assign sample_evt = (state == RUN) && (down_cnt == 32'd1) && !start_i && !stop_i;

  // --------------------------------------------------------------------------
  // Session control: state, interval down-counter and timestamp.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      busy     <= 1'b0;
      down_cnt <= '0;
      ts       <= '0;
    end else if (stop_i) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else if (start_i) begin
      state    <= RUN;
      busy     <= 1'b1;
      down_cnt <= reload_val;
      ts       <= '0;
    end else if (state == RUN) begin
      ts       <= ts + TsWidth'(1);
      down_cnt <= (down_cnt == 32'd1) ? reload_val : down_cnt - 32'd1;
    end
  end

  assign busy_o = busy;

  // --------------------------------------------------------------------------
  // Counter field formation: absolute values or deltas against a baseline.
  // --------------------------------------------------------------------------
`ifdef SNITCH_PERF_SAMPLER_DELTA_EN
  logic [NumCounters*CntWidth-1:0] baseline;

  // Baselines move only on an accepted push, so a dropped snapshot's interval
  // is folded into the next delivered delta.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baseline <= '0;
    end else if ((start_i && !stop_i) || push) begin
      baseline <= cnt_i;
    end
  end

  for (genvar k = 0; k < NumCounters; k++) begin : g_delta
    assign cnt_field[k*CntWidth +: CntWidth] =
        cnt_i[k*CntWidth +: CntWidth] - baseline[k*CntWidth +: CntWidth];
  end
`else
  assign cnt_field = cnt_i;
`endif

  // --------------------------------------------------------------------------
  // Snapshot FIFO. A pop in the same cycle frees a slot for a push into a
  // full FIFO, so only a full-and-not-popping FIFO drops.
  // --------------------------------------------------------------------------
  assign full           = (count == (PTR_W+1)'(FifoDepth));
  assign sample_valid_o = (count != '0);
  assign pop            = sample_valid_o && sample_ready_i;
  assign push           = sample_evt && (!full || pop);
  assign drop           = sample_evt && full && !pop;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {ts, cnt_field};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; gating keeps the head at zero while empty.
  assign sample_data_o = sample_valid_o ? mem[rd_ptr] : '0;
  assign fill_o        = count;

  // --------------------------------------------------------------------------
  // Drop accounting. clear_i wins over a simultaneous drop.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

endmodule
`default_nettype wire
